axi_pkt_rr_arbiter: RTL and testbench

//  Packet-granular round-robin arbiter: shares one 32-bit AXI-stream datapath (e.g. the loopback axi_fifo

---
 rtl/axi_pkt_rr_arbiter_pkg.sv | 12 +
 rtl/axi_pkt_rr_arbiter_if.sv | 27 ++
 rtl/axi_pkt_rr_arbiter_rr_priority_encoder.sv | 28 ++
 rtl/axi_pkt_rr_arbiter.sv | 103 ++++++++++
 tb/tb_axi_pkt_rr_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_pkt_rr_arbiter_pkg.sv
// Shared definitions for the packet round-robin arbiter:
// default settings-bus address and FSM state encodings.
package axi_pkt_rr_arbiter_pkg;

    localparam logic [7:0] SR_ARB_MASK_DFLT = 8'd130;

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_XFER = 1'b1
    } state_t;

endpackage

// File: rtl/axi_pkt_rr_arbiter_if.sv
// Requester-side and shared-datapath AXI-stream bundle.
// master = stream sources/sink side, slave = the arbiter.
interface axi_pkt_rr_arbiter_if #(
    parameter int NUM_PORTS = 4,
    parameter int WIDTH     = 32
);

    logic [NUM_PORTS*WIDTH-1:0] i_tdata;
    logic [NUM_PORTS-1:0]       i_tlast;
    logic [NUM_PORTS-1:0]       i_tvalid;
    logic [NUM_PORTS-1:0]       i_tready;
    logic [WIDTH-1:0]           o_tdata;
    logic                       o_tlast;
    logic                       o_tvalid;
    logic                       o_tready;

    modport master (
        output i_tdata, i_tlast, i_tvalid, o_tready,
        input  i_tready, o_tdata, o_tlast, o_tvalid
    );

    modport slave (
        input  i_tdata, i_tlast, i_tvalid, o_tready,
        output i_tready, o_tdata, o_tlast, o_tvalid
    );

endinterface

// File: rtl/axi_pkt_rr_arbiter_rr_priority_encoder.sv
// Round-robin priority search: first requester after last_grant,
// wrapping around, purely combinational.
module rr_priority_encoder #(
    parameter int NUM_PORTS = 4,
    parameter int GW        = 2
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [GW-1:0]        last_grant,
    output logic                 found,
    output logic [GW-1:0]        idx
);

    // scan last_grant+1 .. last_grant (mod NUM_PORTS), first hit wins
    always_comb begin
        int p;
        found = 1'b0;
        idx   = '0;
        p     = 0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            p = (int'(last_grant) + i) % NUM_PORTS;
            if (!found && req[p]) begin
                found = 1'b1;
                idx   = GW'(p);
            end
        end
    end

endmodule

// File: rtl/axi_pkt_rr_arbiter.sv
// Packet-granular round-robin arbiter sharing one AXI-stream
// datapath; grant held from first beat through tlast.
import axi_pkt_rr_arbiter_pkg::*;

module axi_pkt_rr_arbiter #(
    parameter int         NUM_PORTS   = 4,
    parameter int         WIDTH       = 32,
    parameter logic [7:0] SR_ARB_MASK = SR_ARB_MASK_DFLT,
    localparam int        GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 set_stb,
    input  logic [7:0]           set_addr,
    input  logic [31:0]          set_data,
    axi_pkt_rr_arbiter_if.slave  bus,
    output logic [GW-1:0]        grant,
    output logic                 busy
);

    state_t               state;
    state_t               state_nxt;
    logic [NUM_PORTS-1:0] mask;
    logic [NUM_PORTS-1:0] req;
    logic [GW-1:0]        last_grant;
    logic [GW-1:0]        idx;
    logic                 found;
    logic                 beat;
    logic                 unused_set_data;

    assign unused_set_data = ^set_data;
    assign req  = bus.i_tvalid & mask;
    assign beat = bus.o_tvalid & bus.o_tready;
    assign busy = (state == ST_XFER);

    rr_priority_encoder #(
        .NUM_PORTS(NUM_PORTS),
        .GW(GW)
    ) u_enc (
        .req(req),
        .last_grant(last_grant),
        .found(found),
        .idx(idx)
    );

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= ST_ARB;
        else
            state <= state_nxt;
    end

    // next state: arbitrate when idle, release after the tlast beat
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_ARB:  if (found) state_nxt = ST_XFER;
            ST_XFER: if (beat && bus.o_tlast) state_nxt = ST_ARB;
            default: state_nxt = ST_ARB;
        endcase
    end

    // latch the winner on entry to XFER, remember it for rotation at tlast
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant      <= '0;
            last_grant <= GW'(NUM_PORTS - 1);
        end else begin
            if (state == ST_ARB && found)
                grant <= idx;
            if (state == ST_XFER && beat && bus.o_tlast)
                last_grant <= grant;
        end
    end

    // requester-enable mask written from the settings bus
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            mask <= '1;
        else if (set_stb && set_addr == SR_ARB_MASK)
            mask <= set_data[NUM_PORTS-1:0];
    end

    // zero-latency mux from the granted port while in XFER
    always_comb begin
        bus.o_tdata  = '0;
        bus.o_tlast  = 1'b0;
        bus.o_tvalid = 1'b0;
        bus.i_tready = '0;
        if (state == ST_XFER) begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                if (grant == GW'(k)) begin
                    bus.o_tdata     = bus.i_tdata[k*WIDTH +: WIDTH];
                    bus.o_tlast     = bus.i_tlast[k];
                    bus.o_tvalid    = bus.i_tvalid[k];
                    bus.i_tready[k] = bus.o_tready;
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_pkt_rr_arbiter.sv
// Directed bench for axi_pkt_rr_arbiter: ordering, masking,
// stalls, reset mid-packet, checked against a beat log.
module tb_axi_pkt_rr_arbiter;

    localparam int NP = 4;
    localparam int W  = 32;

    logic        clk      = 1'b0;
    logic        reset    = 1'b0;
    logic        set_stb  = 1'b0;
    logic [7:0]  set_addr = 8'd0;
    logic [31:0] set_data = 32'd0;
    logic [1:0]  grant;
    logic        busy;

    axi_pkt_rr_arbiter_if #(.NUM_PORTS(NP), .WIDTH(W)) bus ();

    axi_pkt_rr_arbiter #(
        .NUM_PORTS(NP),
        .WIDTH(W),
        .SR_ARB_MASK(8'd130)
    ) dut (
        .clk(clk),
        .reset(reset),
        .set_stb(set_stb),
        .set_addr(set_addr),
        .set_data(set_data),
        .bus(bus.slave),
        .grant(grant),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    int cyc = 0;
    int bad_rdy = 0;
    int sent [NP];
    int len  [NP];
    int npkt [NP];
    int hold [NP];
    bit rnd = 1'b0;

    int          lp [$];
    logic [31:0] ld [$];
    logic        ll [$];
    int          lc [$];

    int e3 [8] = '{3, 3, 1, 1, 3, 3, 1, 1};

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int k = 0; k < NP; k++) begin
            bus.i_tvalid[k] = (npkt[k] > 0) && (hold[k] == 0);
            bus.i_tlast[k]  = (sent[k] == len[k] - 1);
            bus.i_tdata[k*W +: W] = {8'(k), 8'(npkt[k]), 16'(sent[k])};
        end
    endtask

    // one clock: sample before the edge, advance sources after it
    task automatic cycle();
        logic [NP-1:0] fire;
        logic [NP-1:0] ok;
        #1;
        fire = bus.i_tvalid & bus.i_tready;
        ok   = busy ? (NP'(1) << grant) : '0;
        if ((bus.i_tready & ~ok) != '0)
            bad_rdy++;
        if (bus.o_tvalid && bus.o_tready) begin
            lp.push_back(int'(grant));
            ld.push_back(bus.o_tdata);
            ll.push_back(bus.o_tlast);
            lc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < NP; k++) begin
            if (fire[k]) begin
                if (sent[k] == len[k] - 1) begin
                    sent[k] = 0;
                    npkt[k]--;
                end else begin
                    sent[k]++;
                end
            end
            if (hold[k] > 0)
                hold[k]--;
        end
        if (rnd)
            bus.o_tready = 1'($urandom_range(0, 1));
        drive();
    endtask

    task automatic clr_log();
        lp.delete();
        ld.delete();
        ll.delete();
        lc.delete();
        bad_rdy = 0;
    endtask

    task automatic clr_model();
        for (int k = 0; k < NP; k++) begin
            sent[k] = 0;
            len[k]  = 1;
            npkt[k] = 0;
            hold[k] = 0;
        end
        drive();
    endtask

    task automatic start(input int k, input int n, input int l);
        npkt[k] = n;
        len[k]  = l;
        sent[k] = 0;
        drive();
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        set_stb      = 1'b0;
        rnd          = 1'b0;
        bus.o_tready = 1'b1;
        clr_model();
        clr_log();
        #1;
        chk("rst_tvalid", 32'(bus.o_tvalid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_tready", 32'(bus.i_tready), 0);
        chk("rst_grant", 32'(grant), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc   = 0;
    endtask

    task automatic setw(input logic [7:0] a, input logic [31:0] d);
        set_stb  = 1'b1;
        set_addr = a;
        set_data = d;
        cycle();
        set_stb  = 1'b0;
    endtask

    initial begin
        bit held;
        int guard;
        #2;
        do_reset();

        // four simultaneous 3-beat packets, strict 0,1,2,3 order
        for (int k = 0; k < NP; k++)
            start(k, 1, 3);
        guard = 0;
        while (lp.size() < 12 && guard < 60) begin
            cycle();
            guard++;
        end
        chk("t1_beats", lp.size(), 12);
        for (int j = 0; j < 12; j++) begin
            chk("t1_port", lp[j], j / 3);
            chk("t1_data", ld[j], {8'(j / 3), 8'd1, 16'(j % 3)});
            chk("t1_last", 32'(ll[j]), 32'(j % 3 == 2));
            if (j > 0)
                chk("t1_gap", lc[j] - lc[j-1], (j % 3 == 0) ? 2 : 1);
        end
        chk("t1_rdy", bad_rdy, 0);
        repeat (2) cycle();

        // late requester must wait for the whole in-flight packet
        clr_log();
        start(2, 1, 4);
        held  = 1'b0;
        guard = 0;
        while (lp.size() < 6 && guard < 40) begin
            cycle();
            if (!held && sent[2] == 1) begin
                held = 1'b1;
                start(1, 1, 2);
            end
            guard++;
        end
        chk("t2_beats", lp.size(), 6);
        for (int j = 0; j < 6; j++) begin
            chk("t2_port", lp[j], (j < 4) ? 2 : 1);
            chk("t2_data", ld[j], (j < 4) ? {8'd2, 8'd1, 16'(j)}
                                          : {8'd1, 8'd1, 16'(j - 4)});
        end
        chk("t2_gap", lc[4] - lc[3], 2);
        chk("t2_rdy", bad_rdy, 0);

        // mask 1010 then a write to another address that must be ignored
        clr_log();
        setw(8'd130, 32'h0000_000A);
        setw(8'd131, 32'h0000_0000);
        for (int k = 0; k < NP; k++)
            start(k, 2, 2);
        repeat (40) cycle();
        chk("t3_beats", lp.size(), 8);
        for (int j = 0; j < 8; j++)
            chk("t3_port", lp[j], e3[j]);
        chk("t3_rdy", bad_rdy, 0);

        // masking the granted port mid-packet lets that packet finish
        do_reset();
        start(0, 2, 3);
        start(1, 2, 3);
        guard = 0;
        while (sent[0] != 1 && guard < 20) begin
            cycle();
            guard++;
        end
        chk("t4_mid", sent[0], 1);
        setw(8'd130, 32'h0000_000E);
        repeat (30) cycle();
        chk("t4_beats", lp.size(), 9);
        for (int j = 0; j < 9; j++)
            chk("t4_port", lp[j], (j < 3) ? 0 : 1);
        for (int j = 0; j < 3; j++)
            chk("t4_data", ld[j], {8'd0, 8'd2, 16'(j)});

        // random backpressure with a 3-cycle source stall mid-packet
        do_reset();
        rnd = 1'b1;
        start(0, 1, 6);
        start(3, 1, 4);
        held  = 1'b0;
        guard = 0;
        while (lp.size() < 10 && guard < 300) begin
            if (!held && sent[0] == 2) begin
                held    = 1'b1;
                hold[0] = 3;
                drive();
            end
            if (hold[0] > 0) begin
                #1;
                chk("t5_busy", 32'(busy), 1);
                chk("t5_grant", 32'(grant), 0);
                chk("t5_tvalid", 32'(bus.o_tvalid), 0);
            end
            cycle();
            guard++;
        end
        rnd          = 1'b0;
        bus.o_tready = 1'b1;
        chk("t5_beats", lp.size(), 10);
        for (int j = 0; j < 10; j++) begin
            chk("t5_port", lp[j], (j < 6) ? 0 : 3);
            chk("t5_data", ld[j], (j < 6) ? {8'd0, 8'd1, 16'(j)}
                                          : {8'd3, 8'd1, 16'(j - 6)});
        end
        chk("t5_rdy", bad_rdy, 0);

        // reset during the second beat of a 5-beat packet
        do_reset();
        start(0, 1, 5);
        guard = 0;
        while (sent[0] != 1 && guard < 20) begin
            cycle();
            guard++;
        end
        chk("t6_mid_busy", 32'(busy), 1);
        reset = 1'b1;
        #1;
        chk("t6_tvalid", 32'(bus.o_tvalid), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_tready", 32'(bus.i_tready), 0);
        do_reset();
        start(2, 1, 1);
        start(0, 1, 1);
        guard = 0;
        while (lp.size() < 2 && guard < 20) begin
            cycle();
            guard++;
        end
        chk("t6_beats", lp.size(), 2);
        chk("t6_first", lp[0], 0);
        chk("t6_second", lp[1], 2);
        chk("t6_last0", 32'(ll[0]), 1);
        chk("t6_last1", 32'(ll[1]), 1);
        chk("t6_gap", lc[1] - lc[0], 2);

        // all-zero mask keeps the arbiter idle
        clr_log();
        setw(8'd130, 32'h0000_0000);
        start(1, 1, 2);
        repeat (10) cycle();
        chk("t7_beats", lp.size(), 0);
        chk("t7_busy", 32'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
